// File: rtl/fp_mult_mantissa_core.sv
// -----------------------------------------------------------------------------
// fp_mult_mantissa_core
//
// Upstream stage of the single-precision floating-point multiplier. A start
// strobe in IDLE latches two binary32 operands and unpacks them: the hidden
// bit is restored for normal numbers, and denormals or zeros flush to a zero
// significand. The stage also forms the result sign and the biased exponent
// sum. A radix-2 shift-add loop of 24 iterations then builds the 48-bit
// significand product. The result is published together with a one-cycle
// valid pulse, and it holds until the next result is published.
//
// Ports
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset
//   start    in   1   request, sampled only in IDLE
//   a        in  32   operand A (binary32)
//   b        in  32   operand B (binary32)
//   busy     out  1   high while the shift-add loop runs
//   valid    out  1   one-cycle pulse, P/exp_sum/sign hold a new result
//   P        out 48   unsigned product of the 24-bit significands
//   exp_sum  out 10   biased exponent sum, two's complement, modulo 2^10
//   sign     out  1   a[31] ^ b[31]
// -----------------------------------------------------------------------------
module fp_mult_mantissa_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        valid,
    output logic [47:0] P,
    output logic [9:0]  exp_sum,
    output logic        sign
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] LAST_ITER = 5'd23;
    localparam logic [9:0] EXP_BIAS  = 10'd127;

    // Restores the hidden bit. A zero exponent field (zero or denormal)
    // flushes the whole significand to zero.
    function automatic logic [23:0] unpack_sig(input logic [31:0] op);
        logic [23:0] sig;
        if (op[30:23] != 8'd0) begin
            sig = {1'b1, op[22:0]};
        end else begin
            sig = 24'd0;
        end
        return sig;
    endfunction

    // Biased exponent sum with the extra bias removed once. The result wraps
    // modulo 2^10, and Inf/NaN fields are summed like any other field.
    function automatic logic [9:0] add_exp(input logic [31:0] op_a, input logic [31:0] op_b);
        logic [9:0] total;
        total = {2'b00, op_a[30:23]} + {2'b00, op_b[30:23]} - EXP_BIAS;
        return total;
    endfunction

    // Performs one shift-add step. The multiplicand is added when the
    // current multiplier LSB is set.
    function automatic logic [47:0] shift_add_step(input logic [47:0] acc,
                                                   input logic [47:0] mcand,
                                                   input logic        mb_lsb);
        logic [47:0] sum;
        if (mb_lsb) begin
            sum = acc + mcand;
        end else begin
            sum = acc;
        end
        return sum;
    endfunction

    // Registered state
    logic [1:0]  state_r;
    logic [47:0] mcand_r;
    logic [23:0] mb_shift_r;
    logic [47:0] acc_r;
    logic [4:0]  count_r;
    logic [9:0]  exp_r;
    logic        sign_r;

    // Next-state values
    logic [1:0]  state_s;
    logic [47:0] mcand_s;
    logic [23:0] mb_shift_s;
    logic [47:0] acc_s;
    logic [4:0]  count_s;
    logic [9:0]  exp_s;
    logic        sign_s;
    logic        busy_s;
    logic        valid_s;
    logic [47:0] p_s;
    logic [9:0]  exp_sum_s;
    logic        sign_out_s;
    logic [47:0] partial_s;

    // Accumulator value after the iteration in progress
    always_comb begin
        partial_s = shift_add_step(acc_r, mcand_r, mb_shift_r[0]);
    end

    // Sequencing and datapath next-state logic
    always_comb begin
        state_s    = state_r;
        mcand_s    = mcand_r;
        mb_shift_s = mb_shift_r;
        acc_s      = acc_r;
        count_s    = count_r;
        exp_s      = exp_r;
        sign_s     = sign_r;
        busy_s     = busy;
        valid_s    = 1'b0;
        p_s        = P;
        exp_sum_s  = exp_sum;
        sign_out_s = sign;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_MULT;
                    mcand_s    = {24'd0, unpack_sig(a)};
                    mb_shift_s = unpack_sig(b);
                    acc_s      = 48'd0;
                    count_s    = 5'd0;
                    exp_s      = add_exp(a, b);
                    sign_s     = a[31] ^ b[31];
                    busy_s     = 1'b1;
                end else begin
                    busy_s     = 1'b0;
                end
            end

            ST_MULT: begin
                acc_s      = partial_s;
                mcand_s    = {mcand_r[46:0], 1'b0};
                mb_shift_s = {1'b0, mb_shift_r[23:1]};
                count_s    = count_r + 5'd1;
                if (count_r == LAST_ITER) begin
                    // Publish on the last iteration edge so that the result
                    // and valid are visible throughout the DONE cycle. The
                    // final addend goes straight from partial_s to P.
                    state_s    = ST_DONE;
                    count_s    = 5'd0;
                    busy_s     = 1'b0;
                    valid_s    = 1'b1;
                    p_s        = partial_s;
                    exp_sum_s  = exp_r;
                    sign_out_s = sign_r;
                end else begin
                    busy_s     = 1'b1;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end

            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset clears everything asynchronously and
    // aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            mcand_r    <= 48'd0;
            mb_shift_r <= 24'd0;
            acc_r      <= 48'd0;
            count_r    <= 5'd0;
            exp_r      <= 10'd0;
            sign_r     <= 1'b0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            P          <= 48'd0;
            exp_sum    <= 10'd0;
            sign       <= 1'b0;
        end else begin
            state_r    <= state_s;
            mcand_r    <= mcand_s;
            mb_shift_r <= mb_shift_s;
            acc_r      <= acc_s;
            count_r    <= count_s;
            exp_r      <= exp_s;
            sign_r     <= sign_s;
            busy       <= busy_s;
            valid      <= valid_s;
            P          <= p_s;
            exp_sum    <= exp_sum_s;
            sign       <= sign_out_s;
        end
    end

endmodule

// File: tb/tb_fp_mult_mantissa_core.sv
module tb_fp_mult_mantissa_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        valid;
    logic [47:0] P;
    logic [9:0]  exp_sum;
    logic        sign;

    int errors = 0;
    int checks = 0;

    logic [47:0] prev_p;
    logic [9:0]  prev_e;
    logic        prev_s;

    fp_mult_mantissa_core dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .valid   (valid),
        .P       (P),
        .exp_sum (exp_sum),
        .sign    (sign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: plain arithmetic on unpacked fields
    function automatic longint unsigned ref_sig(input logic [31:0] x);
        if (x[30:23] != 8'd0) return 64'h800000 + longint'(x[22:0]);
        else return 64'd0;
    endfunction

    function automatic logic [47:0] ref_p(input logic [31:0] x, input logic [31:0] y);
        longint unsigned prod;
        prod = ref_sig(x) * ref_sig(y);
        return prod[47:0];
    endfunction

    function automatic logic [9:0] ref_exp(input logic [31:0] x, input logic [31:0] y);
        int s;
        s = int'(x[30:23]) + int'(y[30:23]) - 127;
        return s[9:0];
    endfunction

    // One operation from IDLE, checking latency, busy, output hold and result
    task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b,
                         input bit disturb, input string tag);
        logic [47:0] ep;
        logic [9:0]  ee;
        logic        es;
        bit          seen;
        int          lat;
        ep = ref_p(op_a, op_b);
        ee = ref_exp(op_a, op_b);
        es = op_a[31] ^ op_b[31];
        seen = 1'b0;
        lat = 0;
        @(negedge clk);
        a = op_a; b = op_b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        check({tag, " hold_P_at_accept"}, 64'(P), 64'(prev_p));
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (disturb) begin
                a = $urandom; b = $urandom;
                start = (k == 5 || k == 20);
            end
            @(posedge clk);
            @(negedge clk);
            if (k == 12) begin
                check({tag, " hold_P_mid"}, 64'(P), 64'(prev_p));
                check({tag, " hold_exp_mid"}, 64'(exp_sum), 64'(prev_e));
                check({tag, " hold_sign_mid"}, 64'(sign), 64'(prev_s));
            end
            if (valid) begin
                seen = 1'b1;
                lat = k;
            end
        end
        start = 1'b0;
        if (!seen) begin
            check({tag, " valid_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, " latency"}, 64'(lat), 64'd24);
            check({tag, " busy_at_valid"}, 64'(busy), 64'd0);
            check({tag, " P"}, 64'(P), 64'(ep));
            check({tag, " exp_sum"}, 64'(exp_sum), 64'(ee));
            check({tag, " sign"}, 64'(sign), 64'(es));
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, " valid_one_cycle"}, 64'(valid), 64'd0);
        check({tag, " P_hold_after"}, 64'(P), 64'(ep));
        prev_p = ep; prev_e = ee; prev_s = es;
    endtask

    initial begin
        int vcount;
        int first_v;
        int second_v;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
        prev_p = 48'd0; prev_e = 10'd0; prev_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset valid", 64'(valid), 64'd0);
        check("reset P", 64'(P), 64'd0);
        check("reset exp_sum", 64'(exp_sum), 64'd0);
        check("reset sign", 64'(sign), 64'd0);
        rst = 1'b0;

        // Directed vectors with hand-derived expectations
        do_op(32'h3F800000, 32'h3F800000, 1'b0, "one_x_one");
        check("one_x_one P const", 64'(P), 64'h400000000000);
        do_op(32'h3FC00000, 32'h3FC00000, 1'b0, "1p5_x_1p5");
        check("1p5 P const", 64'(P), 64'h900000000000);
        do_op(32'hC0000000, 32'h40400000, 1'b0, "m2_x_3");
        check("m2_x_3 P const", 64'(P), 64'h600000000000);
        check("m2_x_3 exp const", 64'(exp_sum), 64'h081);
        check("m2_x_3 sign const", 64'(sign), 64'd1);
        do_op(32'h00000000, 32'h3F800000, 1'b0, "zero_x_one");
        check("zero P const", 64'(P), 64'd0);
        check("zero exp const", 64'(exp_sum), 64'h000);
        do_op(32'h00800000, 32'h00800000, 1'b0, "min_norm");
        check("min_norm exp const", 64'(exp_sum), 64'h383);
        check("min_norm P const", 64'(P), 64'h400000000000);

        // Start pulses and operand changes while busy
        do_op(32'h3FC00000, 32'hC0400000, 1'b1, "busy_ignore");

        // Reset in the middle of the loop
        @(negedge clk);
        a = 32'h3FC00000; b = 32'h3FC00000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst P", 64'(P), 64'd0);
        check("midrst exp_sum", 64'(exp_sum), 64'd0);
        check("midrst sign", 64'(sign), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst valid", 64'(valid), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) vcount++;
        end
        check("midrst no_valid", 64'(vcount), 64'd0);
        prev_p = 48'd0; prev_e = 10'd0; prev_s = 1'b0;
        do_op(32'h3FC00000, 32'h3FC00000, 1'b0, "after_rst");

        // Randomised operands, some with zero exponent fields
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) ra[30:23] = 8'd0;
            if (i % 7 == 3) rb[30:23] = 8'd0;
            do_op(ra, rb, (i % 4 == 0), "random");
        end

        // Start held high: one accept per IDLE visit, 26 cycles apart
        ra = $urandom; rb = $urandom;
        @(negedge clk);
        a = ra; b = rb; start = 1'b1;
        first_v = -1; second_v = -1;
        for (int k = 1; k <= 80 && second_v < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                if (first_v < 0) first_v = k;
                else second_v = k;
            end
        end
        start = 1'b0;
        if (second_v < 0) begin
            check("held_start timeout", 64'd0, 64'd1);
        end else begin
            check("held_start period", 64'(second_v - first_v), 64'd26);
            check("held_start P", 64'(P), 64'(ref_p(ra, rb)));
        end
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
